// File: rtl/axi_arb_pkg.sv
// Shared types and helpers for the AXI-stream round-robin FIFO arbiter.
package axi_arb_pkg;

    // Scheduler states: wait for work, pick a port, move one burst.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARB   = 2'd1,
        BURST = 2'd2
    } arb_state_e;

    localparam int DEFAULT_MAX_BURST = 16;

    // The search helper works on a fixed 8-wide request vector (the largest port count).
    localparam int MAX_SEARCH_PORTS = 8;

    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } search_t;

    // First set request at or after start, wrapping modulo num_ports.
    function automatic search_t rr_search(input logic [MAX_SEARCH_PORTS-1:0] req,
                                          input int                          num_ports,
                                          input logic [2:0]                  start);
        search_t res;
        int      p;
        res = '0;
        for (int i = 0; i < MAX_SEARCH_PORTS; i++) begin
            p = (int'(start) + i) % num_ports;
            if (i < num_ports && !res.found && req[3'(p)]) begin
                res.found = 1'b1;
                res.idx   = 3'(p);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_priority_enc.sv
// Rotating priority encoder: returns the first requesting port at or after start.
module rr_priority_enc
    import axi_arb_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int PORT_BITS = 2
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [PORT_BITS-1:0] start,
    output logic [PORT_BITS-1:0] idx,
    output logic                 found
);

    logic [MAX_SEARCH_PORTS-1:0] req_ext;
    search_t                     res;

    // Widen the request vector to the helper's fixed width and run the search.
    always_comb begin
        req_ext                = '0;
        req_ext[NUM_PORTS-1:0] = req;
        res                    = rr_search(req_ext, NUM_PORTS, 3'(start));
        idx                    = PORT_BITS'(res.idx);
        found                  = res.found;
    end

endmodule

// File: rtl/axi_fifo_rr_arbiter.sv
// Round-robin burst scheduler feeding one downstream AXI-stream FIFO.
// One port is granted per burst; a burst ends on tlast or after MAX_BURST beats.
// The grant index travels with each beat as tid through a single output register.
// Optional build macro ARB_PORT0_PRIORITY_EN: port 0 wins every arbitration it
// requests and does not advance the round-robin pointer.
module axi_fifo_rr_arbiter
    import axi_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_PORTS  = 4,
    parameter int PORT_BITS  = 2,
    parameter int MAX_BURST  = DEFAULT_MAX_BURST,
    parameter int CNT_WIDTH  = 5
) (
    input  logic                            clk,
    input  logic                            sync_reset_n,
    input  logic [NUM_PORTS-1:0]            s_axis_tvalid,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [NUM_PORTS-1:0]            s_axis_tlast,
    output logic [NUM_PORTS-1:0]            s_axis_tready,
    input  logic                            fifo_almost_full,
    output logic                            m_axis_tvalid,
    output logic [DATA_WIDTH-1:0]           m_axis_tdata,
    output logic                            m_axis_tlast,
    output logic [PORT_BITS-1:0]            m_axis_tid,
    input  logic                            m_axis_tready,
    output logic                            grant_active
);

    arb_state_e            state_q,    state_d;
    logic [PORT_BITS-1:0]  rr_ptr_q,   rr_ptr_d;
    logic [PORT_BITS-1:0]  grant_q,    grant_d;
    logic [CNT_WIDTH-1:0]  beat_cnt_q, beat_cnt_d;
    logic                  m_valid_q,  m_valid_d;
    logic [DATA_WIDTH-1:0] m_data_q,   m_data_d;
    logic                  m_last_q,   m_last_d;
    logic [PORT_BITS-1:0]  m_tid_q,    m_tid_d;

    logic [NUM_PORTS-1:0]  enc_req;
    logic [PORT_BITS-1:0]  enc_idx;
    logic                  enc_found;
    logic [PORT_BITS-1:0]  pick_idx;
    logic                  pick_found;

    logic                  sel_valid;
    logic                  sel_last;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  out_free;
    logic                  accept;
    logic                  last_beat;
    logic [PORT_BITS-1:0]  next_ptr;

    rr_priority_enc #(
        .NUM_PORTS (NUM_PORTS),
        .PORT_BITS (PORT_BITS)
    ) u_enc (
        .req   (enc_req),
        .start (rr_ptr_q),
        .idx   (enc_idx),
        .found (enc_found)
    );

    // Choose the winner for the ARB cycle, optionally giving port 0 absolute priority.
    always_comb begin
        enc_req = s_axis_tvalid;
`ifdef ARB_PORT0_PRIORITY_EN
        enc_req[0] = 1'b0;
        if (s_axis_tvalid[0]) begin
            pick_idx   = '0;
            pick_found = 1'b1;
        end else begin
            pick_idx   = enc_idx;
            pick_found = enc_found;
        end
`else
        pick_idx   = enc_idx;
        pick_found = enc_found;
`endif
    end

    // Mux the granted port's beat and derive the handshake and burst-end terms.
    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (grant_q == PORT_BITS'(k)) begin
                sel_valid = s_axis_tvalid[k];
                sel_last  = s_axis_tlast[k];
                sel_data  = s_axis_tdata[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        out_free  = (state_q == BURST) && (!m_valid_q || m_axis_tready);
        accept    = out_free && sel_valid;
        last_beat = sel_last || (beat_cnt_q == CNT_WIDTH'(MAX_BURST - 1));
        next_ptr  = (grant_q == PORT_BITS'(NUM_PORTS - 1)) ? '0 : grant_q + 1'b1;
    end

    // Only the granted port sees ready, and only while the output register can take a beat.
    always_comb begin
        for (int k = 0; k < NUM_PORTS; k++) begin
            s_axis_tready[k] = out_free && (grant_q == PORT_BITS'(k));
        end
    end

    // Next-state, pointer, counter and output-register logic.
    always_comb begin
        // NOTE: every *_d starts from its held value, so no path leaves a signal unassigned (no latches).
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_d    = grant_q;
        beat_cnt_d = beat_cnt_q;
        m_valid_d  = m_valid_q;
        m_data_d   = m_data_q;
        m_last_d   = m_last_q;
        m_tid_d    = m_tid_q;

        // A beat leaves the output register on handshake; otherwise it holds unchanged.
        if (m_valid_q && m_axis_tready) begin
            m_valid_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if ((|s_axis_tvalid) && !fifo_almost_full) begin
                    state_d = ARB;
                end
            end
            ARB: begin
                beat_cnt_d = '0;
                if (pick_found) begin
                    grant_d = pick_idx;
                    state_d = BURST;
                end else begin
                    state_d = IDLE;
                end
            end
            BURST: begin
                if (accept) begin
                    m_valid_d = 1'b1;
                    m_data_d  = sel_data;
                    m_last_d  = last_beat;
                    m_tid_d   = grant_q;
                    if (last_beat) begin
                        // Counter is cleared rather than incremented so it never reaches MAX_BURST.
                        beat_cnt_d = '0;
                        state_d    = IDLE;
`ifdef ARB_PORT0_PRIORITY_EN
                        if (grant_q != '0) begin
                            rr_ptr_d = next_ptr;
                        end
`else
                        rr_ptr_d = next_ptr;
`endif
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register with synchronous active-low reset; a pending output beat is dropped.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!sync_reset_n) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            grant_q    <= '0;
            beat_cnt_q <= '0;
            m_valid_q  <= 1'b0;
            m_data_q   <= '0;
            m_last_q   <= 1'b0;
            m_tid_q    <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_q    <= grant_d;
            beat_cnt_q <= beat_cnt_d;
            m_valid_q  <= m_valid_d;
            m_data_q   <= m_data_d;
            m_last_q   <= m_last_d;
            m_tid_q    <= m_tid_d;
        end
    end

    assign m_axis_tvalid = m_valid_q;
    assign m_axis_tdata  = m_data_q;
    assign m_axis_tlast  = m_last_q;
    assign m_axis_tid    = m_tid_q;
    assign grant_active  = (state_q == BURST);

endmodule

// File: tb/tb_axi_fifo_rr_arbiter.sv
// Self-checking bench for axi_fifo_rr_arbiter: directed scenarios plus a randomized
// phase, all scored against a packet-level round-robin model kept in the bench.
module tb_axi_fifo_rr_arbiter;

    localparam int DW = 32;
    localparam int NP = 4;
    localparam int PB = 2;
    localparam int MB = 16;
    localparam int CW = 5;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [NP-1:0]      s_tvalid;
    logic [NP*DW-1:0]   s_tdata;
    logic [NP-1:0]      s_tlast;
    logic [NP-1:0]      s_tready;
    logic               afull;
    logic               m_tvalid;
    logic [DW-1:0]      m_tdata;
    logic               m_tlast;
    logic [PB-1:0]      m_tid;
    logic               m_tready;
    logic               gact;

    always #5 clk = ~clk;

    axi_fifo_rr_arbiter #(
        .DATA_WIDTH (DW),
        .NUM_PORTS  (NP),
        .PORT_BITS  (PB),
        .MAX_BURST  (MB),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk              (clk),
        .sync_reset_n     (rst_n),
        .s_axis_tvalid    (s_tvalid),
        .s_axis_tdata     (s_tdata),
        .s_axis_tlast     (s_tlast),
        .s_axis_tready    (s_tready),
        .fifo_almost_full (afull),
        .m_axis_tvalid    (m_tvalid),
        .m_axis_tdata     (m_tdata),
        .m_axis_tlast     (m_tlast),
        .m_axis_tid       (m_tid),
        .m_axis_tready    (m_tready),
        .grant_active     (gact)
    );

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    beat_t src_q [NP][$];   // beats still to be offered by each source
    beat_t exp_q [NP][$];   // beats still expected at the output, per port

    int n_checks = 0;
    int n_pass   = 0;

    // Packet-level model state
    int rr_m         = 0;
    int cur_port     = -1;
    int burst_beats  = 0;
    int cyc          = 0;
    int last_end_cyc = -1;
    int burst_ports[$];
    int burst_lens[$];
    int burst_gaps[$];

    logic [NP-1:0]    s_fire;
    logic             prev_stall = 1'b0;
    logic [DW+PB+1:0] prev_out;
    int               stall_checks = 0;
    logic             samp_mvalid;
    logic [PB-1:0]    samp_tid;
    logic [NP-1:0]    samp_sready;
    logic             samp_gact;

    logic auto_ctrl = 1'b1;
    int   ready_pct = 100;
    int   af_pct    = 0;

`ifdef ARB_PORT0_PRIORITY_EN
    int t1_order[5] = '{0, 0, 1, 2, 3};
    int t6_order[5] = '{0, 0, 0, 1, 1};
`else
    int t1_order[5] = '{0, 1, 2, 3, 0};
    int t6_order[5] = '{1, 0, 1, 0, 0};
`endif
    int t2_lens[3] = '{16, 16, 8};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // Which port the scheduling rules say should own the next burst.
    function automatic int pick_port();
`ifdef ARB_PORT0_PRIORITY_EN
        if (exp_q[0].size() > 0) return 0;
`endif
        for (int i = 0; i < NP; i++) begin
            int p;
            p = (rr_m + i) % NP;
`ifdef ARB_PORT0_PRIORITY_EN
            if (p == 0) continue;
`endif
            if (exp_q[p].size() > 0) return p;
        end
        return -1;
    endfunction

    function automatic logic any_pending();
        for (int k = 0; k < NP; k++) if (exp_q[k].size() > 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic drive();
        for (int k = 0; k < NP; k++) begin
            if (src_q[k].size() > 0) begin
                s_tvalid[k]          = 1'b1;
                s_tdata[k*DW +: DW]  = src_q[k][0].data;
                s_tlast[k]           = src_q[k][0].last;
            end else begin
                s_tvalid[k]          = 1'b0;
                s_tdata[k*DW +: DW]  = '0;
                s_tlast[k]           = 1'b0;
            end
        end
    endtask

    task automatic load_pkt(input int port, input int len, input logic has_last);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.data = {8'(port), 24'($urandom)};
            b.last = has_last && (i == len - 1);
            src_q[port].push_back(b);
            exp_q[port].push_back(b);
        end
        drive();
    endtask

    task automatic model_beat();
        beat_t b;
        logic  exp_last;
        int    p;
        if (cur_port < 0) begin
            p = pick_port();
            check("burst_port", 64'(m_tid), 64'(p));
            if (p < 0) return;
            if (last_end_cyc >= 0) burst_gaps.push_back(cyc - last_end_cyc - 1);
            cur_port    = p;
            burst_beats = 0;
            burst_ports.push_back(p);
        end
        if (exp_q[cur_port].size() == 0) begin
            check("extra_beat", 64'(1), 64'(0));
            return;
        end
        b = exp_q[cur_port].pop_front();
        check("tdata", 64'(m_tdata), 64'(b.data));
        check("tid", 64'(m_tid), 64'(cur_port));
        exp_last = b.last || (burst_beats == MB - 1);
        check("tlast", 64'(m_tlast), 64'(exp_last));
        burst_beats++;
        if (exp_last) begin
            burst_lens.push_back(burst_beats);
            last_end_cyc = cyc;
`ifdef ARB_PORT0_PRIORITY_EN
            if (cur_port != 0) rr_m = (cur_port + 1) % NP;
`else
            rr_m = (cur_port + 1) % NP;
`endif
            cur_port = -1;
        end
    endtask

    task automatic monitor();
        check("ready_onehot", 64'($countones(s_tready) <= 1), 64'(1));
        s_fire      = s_tvalid & s_tready;
        samp_mvalid = m_tvalid;
        samp_tid    = m_tid;
        samp_sready = s_tready;
        samp_gact   = gact;
        if (prev_stall) begin
            check("stall_hold", 64'({m_tvalid, m_tdata, m_tid, m_tlast}), 64'(prev_out));
            stall_checks++;
        end
        prev_stall = m_tvalid && !m_tready;
        if (prev_stall) begin
            prev_out = {m_tvalid, m_tdata, m_tid, m_tlast};
            check("stall_sready", 64'(s_tready), 64'(0));
        end
        if (m_tvalid && m_tready) model_beat();
    endtask

    // One clock: sample at the falling edge, update sources just after the rising edge.
    task automatic cycle();
        @(negedge clk);
        monitor();
        @(posedge clk);
        cyc++;
        #1;
        for (int k = 0; k < NP; k++) if (s_fire[k]) void'(src_q[k].pop_front());
        drive();
        if (auto_ctrl) begin
            m_tready = ($urandom_range(0, 99) < ready_pct);
            afull    = ($urandom_range(0, 99) < af_pct);
        end
    endtask

    task automatic drain(input string tag, input int budget);
        int n;
        n = 0;
        while ((any_pending() || cur_port >= 0) && n < budget) begin
            cycle();
            n++;
        end
        check(tag, 64'(n < budget), 64'(1));
    endtask

    task automatic clear_hist();
        burst_ports.delete();
        burst_lens.delete();
        burst_gaps.delete();
        last_end_cyc = -1;
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int st0;
        rst_n    = 1'b0;
        s_tvalid = '0;
        s_tdata  = '0;
        s_tlast  = '0;
        afull    = 1'b0;
        m_tready = 1'b1;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_mvalid", 64'(m_tvalid), 64'(0));
        check("rst_tdata",  64'(m_tdata),  64'(0));
        check("rst_tlast",  64'(m_tlast),  64'(0));
        check("rst_tid",    64'(m_tid),    64'(0));
        check("rst_sready", 64'(s_tready), 64'(0));
        check("rst_gact",   64'(gact),     64'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // All four ports busy with 4-beat packets
        clear_hist();
        load_pkt(0, 4, 1'b1);
        load_pkt(0, 4, 1'b1);
        for (int k = 1; k < NP; k++) load_pkt(k, 4, 1'b1);
        drain("t1_drain", 2000);
        check("t1_nbursts", 64'(burst_ports.size()), 64'(5));
        for (int i = 0; i < burst_ports.size() && i < 5; i++) begin
            check("t1_order", 64'(burst_ports[i]), 64'(t1_order[i]));
            check("t1_len",   64'(burst_lens[i]),  64'(4));
        end

        // Port 2 alone, 40 beats: split by MAX_BURST, two idle cycles between bursts
        clear_hist();
        load_pkt(2, 40, 1'b1);
        drain("t2_drain", 2000);
        check("t2_nbursts", 64'(burst_lens.size()), 64'(3));
        for (int i = 0; i < burst_lens.size() && i < 3; i++)
            check("t2_len", 64'(burst_lens[i]), 64'(t2_lens[i]));
        check("t2_ngaps", 64'(burst_gaps.size()), 64'(2));
        for (int i = 0; i < burst_gaps.size(); i++)
            check("t2_gap", 64'(burst_gaps[i]), 64'(2));

        // Reset in the middle of a port-3 burst
        clear_hist();
        load_pkt(3, 10, 1'b1);
        n = 0;
        while (exp_q[3].size() > 7 && n < 200) begin
            cycle();
            n++;
        end
        check("t3_burst_started", 64'(n < 200), 64'(1));
        check("t3_gact_before", 64'(gact), 64'(1));
        rst_n = 1'b0;
        @(posedge clk);
        cyc++;
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < NP; k++) begin
            src_q[k].delete();
            exp_q[k].delete();
        end
        drive();
        rr_m       = 0;
        cur_port   = -1;
        prev_stall = 1'b0;
        @(negedge clk);
        check("t3_mvalid", 64'(m_tvalid), 64'(0));
        check("t3_tdata",  64'(m_tdata),  64'(0));
        check("t3_tlast",  64'(m_tlast),  64'(0));
        check("t3_tid",    64'(m_tid),    64'(0));
        check("t3_sready", 64'(s_tready), 64'(0));
        check("t3_gact",   64'(gact),     64'(0));
        @(posedge clk);
        cyc++;
        #1;
        clear_hist();
        load_pkt(1, 5, 1'b1);
        load_pkt(3, 5, 1'b1);
        drain("t3_drain", 2000);
        check("t3_nbursts", 64'(burst_ports.size()), 64'(2));
        if (burst_ports.size() > 0) check("t3_first_port", 64'(burst_ports[0]), 64'(1));

        // almost_full holds the scheduler in IDLE
        auto_ctrl = 1'b0;
        m_tready  = 1'b1;
        afull     = 1'b1;
        clear_hist();
        load_pkt(1, 1, 1'b1);
        repeat (4) begin
            cycle();
            check("af_sready", 64'(samp_sready), 64'(0));
            check("af_gact",   64'(samp_gact),   64'(0));
            check("af_mvalid", 64'(samp_mvalid), 64'(0));
        end
        afull = 1'b0;
        n = 0;
        while (n < 10) begin
            cycle();
            if (samp_mvalid) break;
            n++;
        end
        check("af_latency", 64'(n), 64'(3));
        check("af_tid", 64'(samp_tid), 64'(1));
        drain("af_drain", 200);

        // Downstream stall of 5 cycles mid-burst
        clear_hist();
        load_pkt(0, 8, 1'b1);
        n = 0;
        while (exp_q[0].size() > 5 && n < 200) begin
            cycle();
            n++;
        end
        check("stall_started", 64'(n < 200), 64'(1));
        st0      = stall_checks;
        m_tready = 1'b0;
        repeat (5) cycle();
        m_tready = 1'b1;
        drain("stall_drain", 200);
        check("stall_seen", 64'((stall_checks - st0) >= 4), 64'(1));
        check("stall_nbursts", 64'(burst_lens.size()), 64'(1));

        // Ports 0 and 1 competing with 2-beat packets
        clear_hist();
        load_pkt(0, 2, 1'b1);
        load_pkt(0, 2, 1'b1);
        load_pkt(0, 2, 1'b1);
        load_pkt(1, 2, 1'b1);
        load_pkt(1, 2, 1'b1);
        drain("t6_drain", 500);
        check("t6_nbursts", 64'(burst_ports.size()), 64'(5));
        for (int i = 0; i < burst_ports.size() && i < 5; i++)
            check("t6_order", 64'(burst_ports[i]), 64'(t6_order[i]));

        // Randomized traffic with random backpressure and almost_full
        auto_ctrl = 1'b1;
        ready_pct = 70;
        af_pct    = 20;
        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < NP; k++) begin
                int npk;
                npk = $urandom_range(0, 3);
                for (int j = 0; j < npk; j++) load_pkt(k, $urandom_range(1, 24), 1'b1);
            end
            drain("rand_drain", 8000);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
